alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Controller that shares one combinational 4-bit ALU between two requesters.
- Arbitrates with round-robin, latches the winning request, drives the ALU operand/opcode bus and waits a fixed settle time.
- Captures the 5-bit ALU result and returns it to the winning requester with a valid/ready handshake.
- Sits between the two operation sources and the ALU instance; the ALU itself is external.

Parameters:
- DW, 4, operand width; results are DW+1 bits.
- OPW, 4, opcode width.
- SETTLE, 1, ALU settle time in cycles between operand drive and result capture; legal range 1..15.
- NUM_OPS, 7, number of legal opcodes (0..NUM_OPS-1). Encoding: 0 add, 1 sub, 2 mul, 3 div (remainder), 4 parity, 5 AND, 6 OR.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst_n  in  1  Reset; asynchronous, active-low.
- req0_valid  in  1  Requester 0 has an operation.
- req0_ready  out  1  Requester 0 operation accepted this cycle.
- req0_op  in  OPW  Requester 0 opcode.
- req0_a, req0_b  in  DW each  Requester 0 operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b  —  Same as requester 0, for requester 1.
- rsp0_valid  out  1  Result for requester 0 available.
- rsp0_ready  in  1  Requester 0 takes the result.
- rsp1_valid  out  1  Result for requester 1 available.
- rsp1_ready  in  1  Requester 1 takes the result.
- rsp_data  out  DW+1  Result, shared by both response channels.
- rsp_err  out  1  Error flag: illegal opcode or divide by zero.
- alu_op  out  OPW  Opcode to the ALU.
- alu_in1, alu_in2  out  DW each  Operands to the ALU.
- alu_out  in  DW+1  ALU result.
- busy  out  1  High whenever state is not IDLE.
- done_cnt  out  8  Count of completed responses; wraps 255->0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all rsp*_valid=0, rsp_data=0, rsp_err=0, done_cnt=0.
  - alu_op=4'b1111 (NOP), alu_in1=alu_in2=0.
  - last_grant=1, so requester 0 wins first after reset.
  - Reset mid-transaction discards it: no response, no count.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbiter: if only one reqX_valid, that requester is granted. If both are valid, the requester not equal to last_grant is granted.
  - reqX_ready = (state==IDLE) && granted X. It is combinational, so acceptance takes one cycle.
  - On accept (valid&&ready): latch op/a/b and the requester id; set last_grant=id.
  - Illegal request: op>=NUM_OPS, or op==3 with b==0. Go to RESP with rsp_data=0, rsp_err=1; the ALU bus stays at NOP.
  - Otherwise go to EXEC with cnt=0.
- EXEC:
  - alu_op/alu_in1/alu_in2 are driven from the latched registers. They are stable for exactly SETTLE cycles.
  - cnt increments each cycle.
  - At the edge where cnt==SETTLE-1: rsp_data<=alu_out, rsp_err<=0, go to RESP.
  - On leaving EXEC, the ALU bus returns to NOP/0 the next cycle.
- RESP:
  - rspX_valid=1 for the latched id only; the other channel is 0.
  - rsp_data and rsp_err are held stable until rspX_ready.
  - On handshake: go to IDLE, done_cnt+1 (wraps).
  - No new request is accepted in EXEC or RESP; both reqX_ready are 0.
- Latency (accept edge = E0):
  - Legal request: rsp valid from the cycle after edge E0+SETTLE.
  - Illegal request: rsp valid the cycle after E0.
  - Minimum back-to-back rate: one operation per SETTLE+2 cycles, given rsp_ready held high.
- Width rules:
  - Controller does no arithmetic on data; alu_out is passed through unmodified.
  - Operands are passed through unmodified.
  - The divide-by-zero check compares b with 0 at full DW width.
- Simultaneous events: rsp_ready asserted in a cycle where rsp_valid=0 is ignored. The request inputs are sampled only in IDLE.

Test Plan:
- Reset, req0: op=0, a=9, b=8, SETTLE=1, rsp0_ready=1 -> req0_ready high the same cycle. rsp0_valid the 2nd cycle after accept with rsp_data=17, rsp_err=0, done_cnt=1.
- Both valid continuously, 4 ops each -> grants alternate 0,1,0,1,... starting with req0 after reset. Responses go only on the matching rspX_valid.
- req1: op=3, a=7, b=0 -> no ALU drive (alu_op stays 4'b1111). rsp1_valid the cycle after accept, rsp_data=0, rsp_err=1. Same for op=9 with any operands.
- req0: op=2, a=15, b=15, rsp0_ready low for 3 cycles -> rsp0_valid held, rsp_data=225 (5-bit wrap gives 1) stable, busy=1, req1_ready=0 throughout. On ready: IDLE next cycle.
- SETTLE=3, op=5, a=12, b=10 -> alu_in1=12, alu_in2=10, alu_op=5 for exactly 3 cycles. rsp_data=8.
- rst_n pulsed low during EXEC -> all outputs to reset values immediately. The pending result is never returned, done_cnt=0, and the next grant goes to req0.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Round-robin share of one external combinational ALU between two requesters; accept in IDLE,
// result after SETTLE cycles of ALU drive, held on rspX_valid/rsp_data until that requester's ready.
module alu_share_ctrl #(
  parameter int DW      = 4,
  parameter int OPW     = 4,
  parameter int SETTLE  = 1,
  parameter int NUM_OPS = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [DW:0]    rsp_data,
  output logic           rsp_err,
  output logic [OPW-1:0] alu_op,
  output logic [DW-1:0]  alu_in1,
  output logic [DW-1:0]  alu_in2,
  input  logic [DW:0]    alu_out,
  output logic           busy,
  output logic [7:0]     done_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
  } req_t;

  localparam logic [OPW-1:0] OP_NOP   = '1;
  localparam logic [OPW-1:0] OP_DIV   = OPW'(3);
  localparam logic [OPW:0]   OP_LIMIT = (OPW+1)'(NUM_OPS);
  localparam logic [3:0]     CNT_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic       last_grant;
  logic       cur_id;
  logic [3:0] cnt;
  logic       gnt1;
  logic       illegal;
  logic       rsp_hs;
  req_t       in_req;

  // Contention goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    gnt1    = req1_valid && (!req0_valid || !last_grant);
    in_req  = gnt1 ? {req1_op, req1_a, req1_b} : {req0_op, req0_a, req0_b};
    illegal = ({1'b0, in_req.op} >= OP_LIMIT) || ((in_req.op == OP_DIV) && (in_req.b == '0));
    rsp_hs  = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  end

  assign req0_ready = (state == IDLE) && req0_valid && !gnt1;
  assign req1_ready = (state == IDLE) && gnt1;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      cnt        <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      done_cnt   <= '0;
      alu_op     <= OP_NOP;
      alu_in1    <= '0;
      alu_in2    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            cur_id     <= gnt1;
            last_grant <= gnt1;
            if (illegal) begin
              // Rejected ops never touch the ALU bus.
              state      <= RESP;
              rsp_data   <= '0;
              rsp_err    <= 1'b1;
              rsp0_valid <= !gnt1;
              rsp1_valid <= gnt1;
            end else begin
              // The ALU bus registers double as the latched operation.
              state   <= EXEC;
              cnt     <= '0;
              alu_op  <= in_req.op;
              alu_in1 <= in_req.a;
              alu_in2 <= in_req.b;
            end
          end
        end
        EXEC: begin
          cnt <= cnt + 4'd1;
          if (cnt == CNT_LAST) begin
            state      <= RESP;
            rsp_data   <= alu_out;
            rsp_err    <= 1'b0;
            rsp0_valid <= !cur_id;
            rsp1_valid <= cur_id;
            alu_op     <= OP_NOP;
            alu_in1    <= '0;
            alu_in2    <= '0;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            state      <= IDLE;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            done_cnt   <= done_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: transaction-level timing model checked every cycle on a SETTLE=1
// instance, directed vectors with literal expectations, and a SETTLE=3 instance for bus timing.
module tb_alu_share_ctrl;

  localparam int S1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [3:0] req0_op = 0, req0_a = 0, req0_b = 0, req1_op = 0, req1_a = 0, req1_b = 0;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, busy;
  logic [4:0] rsp_data, alu_out;
  logic [3:0] alu_op, alu_in1, alu_in2;
  logic [7:0] done_cnt;

  logic       q_valid = 0, q_rsp_ready = 0;
  logic [3:0] q_op = 0, q_a = 0, q_b = 0;
  logic       q_ready, q1_ready, q_rsp_valid, q1_rsp_valid, q_err, q_busy;
  logic [4:0] q_data, q_alu_out;
  logic [3:0] q_alu_op, q_alu_in1, q_alu_in2;
  logic [7:0] q_done;

  int checks = 0;
  int errors = 0;

  // External ALU behaviour
  function automatic logic [4:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = {4'b0, a} * {4'b0, b};
    case (op)
      4'd0: return {1'b0, a} + {1'b0, b};
      4'd1: return {1'b0, a} - {1'b0, b};
      4'd2: return p[4:0];
      4'd3: return (b == 0) ? 5'd0 : {1'b0, a % b};
      4'd4: return {4'b0, ^{a, b}};
      4'd5: return {1'b0, a & b};
      4'd6: return {1'b0, a | b};
      default: return 5'd0;
    endcase
  endfunction

  assign alu_out   = alu_f(alu_op, alu_in1, alu_in2);
  assign q_alu_out = alu_f(q_alu_op, q_alu_in1, q_alu_in2);

  alu_share_ctrl #(.DW(4), .OPW(4), .SETTLE(S1), .NUM_OPS(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .busy(busy), .done_cnt(done_cnt)
  );

  alu_share_ctrl #(.DW(4), .OPW(4), .SETTLE(3), .NUM_OPS(7)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(q_valid), .req0_ready(q_ready), .req0_op(q_op), .req0_a(q_a), .req0_b(q_b),
    .req1_valid(1'b0), .req1_ready(q1_ready), .req1_op(4'd0), .req1_a(4'd0), .req1_b(4'd0),
    .rsp0_valid(q_rsp_valid), .rsp0_ready(q_rsp_ready), .rsp1_valid(q1_rsp_valid), .rsp1_ready(1'b0),
    .rsp_data(q_data), .rsp_err(q_err), .alu_op(q_alu_op), .alu_in1(q_alu_in1), .alu_in2(q_alu_in2),
    .alu_out(q_alu_out), .busy(q_busy), .done_cnt(q_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: one pending transaction, with response/drive windows derived from the accept cycle.
  logic       m_pend = 0, m_id = 0, m_last = 1, m_legal = 0;
  logic [3:0] m_op = 0, m_a = 0, m_b = 0;
  logic [7:0] m_done = 0;
  int         cyc = 0, m_acc = 0, m_rsp = 0;
  int         grants[$];

  always @(negedge clk) begin : cmp
    logic g1, er0, er1, on, drv;
    cyc++;
    if (!rst_n) begin
      m_pend = 0; m_last = 1; m_done = 0;
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_done_cnt", done_cnt, 0);
      chk("rst_alu_op", alu_op, 15);
      chk("rst_alu_in1", alu_in1, 0);
      chk("rst_alu_in2", alu_in2, 0);
      chk("rst_busy", busy, 0);
    end else begin
      g1  = req1_valid && (!req0_valid || (m_last == 0));
      er0 = !m_pend && req0_valid && !g1;
      er1 = !m_pend && g1;
      on  = m_pend && (cyc >= m_rsp);
      drv = m_pend && m_legal && (cyc > m_acc) && (cyc <= m_acc + S1);
      chk("busy", busy, m_pend);
      chk("req0_ready", req0_ready, er0);
      chk("req1_ready", req1_ready, er1);
      chk("rsp0_valid", rsp0_valid, on && !m_id);
      chk("rsp1_valid", rsp1_valid, on && m_id);
      chk("alu_op", alu_op, drv ? m_op : 4'd15);
      chk("alu_in1", alu_in1, drv ? m_a : 4'd0);
      chk("alu_in2", alu_in2, drv ? m_b : 4'd0);
      chk("done_cnt", done_cnt, m_done);
      if (on) begin
        chk("rsp_data", rsp_data, m_legal ? alu_f(m_op, m_a, m_b) : 5'd0);
        chk("rsp_err", rsp_err, !m_legal);
      end
      if (er0 || er1) begin
        m_pend  = 1;
        m_id    = er1;
        m_last  = er1;
        m_op    = er1 ? req1_op : req0_op;
        m_a     = er1 ? req1_a : req0_a;
        m_b     = er1 ? req1_b : req0_b;
        m_legal = (m_op < 7) && !(m_op == 3 && m_b == 0);
        m_acc   = cyc;
        m_rsp   = cyc + (m_legal ? S1 + 1 : 1);
        grants.push_back(int'(er1));
      end else if (on && (m_id ? rsp1_ready : rsp0_ready)) begin
        m_pend = 0;
        m_done = m_done + 8'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic id, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic ok;
    if (id) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1; end
    else begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1; end
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      #1;
      ok = id ? req1_ready : req0_ready;
      @(posedge clk);
      #1;
    end
    if (id) req1_valid = 0; else req0_valid = 0;
    chk("send_accept", ok, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) tick();
    chk("wait_idle", busy, 0);
  endtask

  logic [3:0] t0ops[4] = '{4'd0, 4'd1, 4'd2, 4'd5};
  logic [3:0] t1ops[4] = '{4'd6, 4'd4, 4'd3, 4'd1};

  initial begin : stim
    int n0, n1, it, dcount, first_drv, first_rsp;
    logic [4:0] qd;

    // Single add after reset
    reset_dut();
    rsp0_ready = 1; rsp1_ready = 1;
    req0_op = 0; req0_a = 9; req0_b = 8; req0_valid = 1;
    #1;
    chk("t1_ready_same_cycle", req0_ready, 1);
    tick();
    req0_valid = 0;
    chk("t1_not_yet_valid", rsp0_valid, 0);
    tick();
    chk("t1_rsp0_valid", rsp0_valid, 1);
    chk("t1_rsp_data", rsp_data, 17);
    chk("t1_rsp_err", rsp_err, 0);
    tick();
    chk("t1_done_cnt", done_cnt, 1);

    // Both requesters continuously valid: strict alternation from req0
    reset_dut();
    grants.delete();
    n0 = 0; n1 = 0; it = 0;
    while ((n0 < 4 || n1 < 4) && it < 100) begin
      req0_valid = (n0 < 4); req1_valid = (n1 < 4);
      req0_op = t0ops[n0 % 4]; req0_a = 4'(n0 * 3 + 1); req0_b = 4'(n0 + 2);
      req1_op = t1ops[n1 % 4]; req1_a = 4'(15 - n1);    req1_b = 4'(n1 + 1);
      #1;
      if (req0_ready) n0++;
      if (req1_ready) n1++;
      @(posedge clk);
      #1;
      it++;
    end
    req0_valid = 0; req1_valid = 0;
    chk("t2_n0", n0, 4);
    chk("t2_n1", n1, 4);
    wait_idle();
    chk("t2_grant_count", grants.size(), 8);
    for (int i = 0; i < grants.size() && i < 8; i++) chk("t2_grant_order", grants[i], i % 2);

    // Illegal requests: divide by zero, then out-of-range opcode
    rsp1_ready = 0;
    send(1, 3, 7, 0);
    chk("t3_div0_rsp1_valid", rsp1_valid, 1);
    chk("t3_div0_rsp0_valid", rsp0_valid, 0);
    chk("t3_div0_data", rsp_data, 0);
    chk("t3_div0_err", rsp_err, 1);
    chk("t3_div0_alu_nop", alu_op, 15);
    rsp1_ready = 1;
    tick();
    rsp1_ready = 0;
    chk("t3_div0_idle", busy, 0);
    send(1, 9, 5, 3);
    chk("t3_op9_rsp1_valid", rsp1_valid, 1);
    chk("t3_op9_err", rsp_err, 1);
    chk("t3_op9_alu_nop", alu_op, 15);
    rsp1_ready = 1;
    tick();
    rsp1_ready = 0;

    // Held response under backpressure while req1 waits
    rsp0_ready = 0;
    req1_op = 0; req1_a = 1; req1_b = 1; req1_valid = 1;
    send(0, 2, 15, 15);
    for (int i = 0; i < 10 && !rsp0_valid; i++) tick();
    for (int i = 0; i < 3; i++) begin
      chk("t4_rsp0_held", rsp0_valid, 1);
      chk("t4_data_held", rsp_data, 1);
      chk("t4_busy", busy, 1);
      chk("t4_req1_blocked", req1_ready, 0);
      tick();
    end
    rsp0_ready = 1; req1_valid = 0;
    tick();
    chk("t4_idle_after_hs", busy, 0);

    // Reset in the middle of EXEC
    send(0, 0, 1, 2);
    chk("t6_in_exec", busy, 1);
    rst_n = 0;
    #1;
    chk("t6_busy_cleared", busy, 0);
    chk("t6_alu_nop", alu_op, 15);
    chk("t6_alu_in1", alu_in1, 0);
    chk("t6_rsp0_valid", rsp0_valid, 0);
    chk("t6_done_cnt", done_cnt, 0);
    tick();
    rst_n = 1;
    req0_op = 0; req0_a = 1; req0_b = 1; req0_valid = 1;
    req1_op = 0; req1_a = 2; req1_b = 2; req1_valid = 1;
    #1;
    chk("t6_req0_wins", req0_ready, 1);
    chk("t6_req1_waits", req1_ready, 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    wait_idle();

    // SETTLE=3 instance: bus held exactly 3 cycles, result on the 4th
    q_op = 5; q_a = 12; q_b = 10; q_valid = 1; q_rsp_ready = 1;
    #1;
    chk("t5_ready", q_ready, 1);
    tick();
    q_valid = 0;
    dcount = 0; first_drv = 0; first_rsp = 0; qd = 0;
    for (int i = 1; i <= 8; i++) begin
      if (q_alu_op == 5 && q_alu_in1 == 12 && q_alu_in2 == 10) begin
        dcount++;
        if (first_drv == 0) first_drv = i;
      end
      if (q_rsp_valid && first_rsp == 0) begin
        first_rsp = i;
        qd = q_data;
      end
      tick();
    end
    chk("t5_drive_cycles", dcount, 3);
    chk("t5_first_drive", first_drv, 1);
    chk("t5_first_rsp", first_rsp, 4);
    chk("t5_rsp_data", qd, 8);
    chk("t5_done_cnt", q_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
